// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin N-requester front end for the single-port data memory.
// One access in flight; illegal addresses are answered with an error and never reach memory.
module dmem_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int XLEN        = 32,
  parameter int DMEM_BYTES  = 4096,
  parameter int MEM_LATENCY = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*XLEN-1:0]   req_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]   req_wdata_i,
  input  logic [NUM_REQ*XLEN/8-1:0] req_be_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic                      rsp_err_o,
  output logic [XLEN-1:0]           rsp_rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [XLEN-1:0]           mem_addr_o,
  output logic [XLEN-1:0]           mem_wdata_o,
  output logic [XLEN/8-1:0]         mem_be_o,
  input  logic [XLEN-1:0]           mem_rdata_i
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int BW = XLEN / 8;
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t state_q;
  logic [IW-1:0] rr_q, owner_q, g;
  logic [IW:0] idx;
  logic [CW-1:0] cnt_q;
  logic we_q, hit, legal, accept, done;
  logic [XLEN-1:0] addr_g;
  // Scan offsets high to low so the smallest offset from rr_q wins.
  always_comb begin
    g = rr_q;
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (IW+1)'(k);
      idx = idx >= (IW+1)'(NUM_REQ) ? idx - (IW+1)'(NUM_REQ) : idx;
      if (req_valid_i[idx[IW-1:0]]) begin
        g = idx[IW-1:0];
        hit = 1'b1;
      end
    end
  end
  assign addr_g = req_addr_i[XLEN*g +: XLEN];
  assign legal  = addr_g < XLEN'(DMEM_BYTES) && addr_g[1:0] == 2'b00;
  assign accept = !rst_i && state_q == IDLE && hit;
  assign done   = !rst_i && (state_q == ERR || (state_q == BUSY && cnt_q == CW'(1)));
  always_comb begin
    req_ready_o = accept ? NUM_REQ'(1) << g : '0;
    mem_en_o    = accept && legal;
    mem_we_o    = mem_en_o && req_we_i[g];
    mem_addr_o  = mem_en_o ? addr_g : '0;
    mem_wdata_o = mem_en_o ? req_wdata_i[XLEN*g +: XLEN] : '0;
    mem_be_o    = mem_en_o ? req_be_i[BW*g +: BW] : '0;
    rsp_valid_o = done ? NUM_REQ'(1) << owner_q : '0;
    rsp_err_o   = done && state_q == ERR;
    rsp_rdata_o = done && state_q == BUSY && !we_q ? mem_rdata_i : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      state_q <= legal ? BUSY : ERR;
      rr_q    <= g == IW'(NUM_REQ - 1) ? '0 : g + 1'b1;
      owner_q <= g;
      cnt_q   <= CW'(MEM_LATENCY);
      we_q    <= req_we_i[g];
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) state_q <= IDLE;
    end else if (state_q == ERR) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios then random traffic, checked every cycle against
// a transaction-level model (grant order, response schedule, byte-addressed memory).
module tb_dmem_arbiter;
  localparam int N = 3;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0] req_valid = '0, req_we = '0, req_ready_o, rsp_valid_o;
  logic [N*32-1:0] req_addr = '0, req_wdata = '0;
  logic [N*4-1:0] req_be = '0;
  logic rsp_err_o, mem_en_o, mem_we_o;
  logic [31:0] rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata;
  logic [3:0] mem_be_o;
  dmem_arbiter #(.NUM_REQ(N), .XLEN(32), .DMEM_BYTES(4096), .MEM_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata));
  always #5 clk = ~clk;
  typedef struct { int c; int o; bit e; logic [31:0] d; } rsp_t;
  int checks = 0, errors = 0, cyc = 0, m_rr = 0, m_free = 0;
  rsp_t rq[$];
  int gq[$];
  logic [N-1:0] acc = '0;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] pipe [LAT];
  logic ref_ok = 1'b0;
  logic [31:0] last_rdata = '0;
  logic last_err = 1'b0;
  function automatic logic [31:0] init_word(input int i);
    return i == 4 ? 32'hDEADBEEF : 32'(i) * 32'h9E3779B9 ^ 32'h5A5A0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  // Memory with LAT-cycle read pipeline; idle slots carry junk so rdata gating is visible.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    else if (mem_en_o && mem_we_o)
      for (int b = 0; b < 4; b++) if (mem_be_o[b]) mem[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    pipe[0] <= mem_en_o && !mem_we_o ? mem[mem_addr_o[11:2]] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];
  logic p_rst = 1'b1;
  logic [N-1:0] p_v = '0, p_rdy = '0, p_we = '0;
  logic [N*32-1:0] p_a = '0, p_d = '0;
  logic [N*4-1:0] p_be = '0;
  always @(negedge clk) begin
    int eg;
    logic [31:0] a, d;
    logic legal;
    rsp_t r;
    if (!ref_ok) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      ref_ok = 1'b1;
    end
    if (!rst_i && !p_rst)
      for (int k = 0; k < N; k++)
        if (p_v[k] && !p_rdy[k])
          assert (req_valid[k] && req_we[k] == p_we[k] && req_addr[k*32 +: 32] == p_a[k*32 +: 32] &&
                  req_wdata[k*32 +: 32] == p_d[k*32 +: 32] && req_be[k*4 +: 4] == p_be[k*4 +: 4])
          else $error("FAIL req_hold: requester %0d changed before ready, valid %b required 1", k, req_valid[k]);
    {p_rst, p_v, p_rdy, p_we, p_a, p_d, p_be} = {rst_i, req_valid, req_ready_o, req_we, req_addr, req_wdata, req_be};
    if (rst_i) begin
      chk("rst_ready", 32'(req_ready_o), 0);
      chk("rst_mem_en", 32'(mem_en_o), 0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
      chk("rst_rsp_err", 32'(rsp_err_o), 0);
      chk("rst_rdata", rsp_rdata_o, 0);
      m_rr = 0;
      m_free = 0;
      rq.delete();
      acc = '0;
    end else begin
      eg = -1;
      if (cyc >= m_free)
        for (int k = 0; k < N; k++) if (eg < 0 && req_valid[(m_rr + k) % N]) eg = (m_rr + k) % N;
      chk("ready", 32'(req_ready_o), eg < 0 ? 0 : 1 << eg);
      if (rq.size() > 0 && rq[0].c == cyc) begin
        r = rq.pop_front();
        chk("rsp_valid", 32'(rsp_valid_o), 1 << r.o);
        chk("rsp_err", 32'(rsp_err_o), 32'(r.e));
        chk("rsp_rdata", rsp_rdata_o, r.d);
      end else chk("rsp_quiet", 32'(rsp_valid_o), 0);
      if (rsp_valid_o != 0) begin
        last_rdata = rsp_rdata_o;
        last_err = rsp_err_o;
      end
      if (eg >= 0) begin
        a = req_addr[eg*32 +: 32];
        legal = a < 32'h1000 && a[1:0] == 2'b00;
        chk("mem_en", 32'(mem_en_o), 32'(legal));
        if (legal) begin
          chk("mem_we", 32'(mem_we_o), 32'(req_we[eg]));
          chk("mem_addr", mem_addr_o, a);
          chk("mem_wdata", mem_wdata_o, req_wdata[eg*32 +: 32]);
          chk("mem_be", 32'(mem_be_o), 32'(req_be[eg*4 +: 4]));
          d = req_we[eg] ? 32'h0 : ref_mem[a[11:2]];
          if (req_we[eg])
            for (int b = 0; b < 4; b++) if (req_be[eg*4 + b]) ref_mem[a[11:2]][8*b +: 8] = req_wdata[eg*32 + 8*b +: 8];
          rq.push_back('{cyc + LAT, eg, 1'b0, d});
          m_free = cyc + LAT + 1;
        end else begin
          rq.push_back('{cyc + 1, eg, 1'b1, 32'h0});
          m_free = cyc + 2;
        end
        m_rr = (eg + 1) % N;
        gq.push_back(eg);
        acc = N'(1) << eg;
      end else begin
        chk("mem_en_idle", 32'(mem_en_o), 0);
        acc = '0;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask
  task automatic set_req(input int r, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_we[r] = we;
    req_addr[r*32 +: 32] = a;
    req_wdata[r*32 +: 32] = d;
    req_be[r*4 +: 4] = be;
    req_valid[r] = 1'b1;
  endtask
  task automatic rand_req(input int r);
    int s;
    logic [31:0] a;
    s = $urandom_range(0, 9);
    a = s == 0 ? ($urandom | 32'h1000) & ~32'h3 :
        s == 1 ? 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(1, 3)) :
        s == 2 ? 32'hFFC : 32'h40 + 32'($urandom_range(0, 15) << 2);
    set_req(r, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
  endtask
  task automatic drain(input string tag);
    int t = 0;
    while ((req_valid != 0 || rq.size() != 0 || cyc < m_free) && t < 500) begin
      tick;
      t++;
    end
    chk(tag, 32'(t < 500), 1);
  endtask
  task automatic wait_grants(input string tag, input int n);
    int t = 0;
    while (gq.size() < n && t < 200) begin
      tick;
      t++;
    end
    chk(tag, 32'(gq.size() >= n), 1);
  endtask
  initial begin
    int base;
    logic [31:0] w;
    repeat (3) tick;
    rst_i = 1'b0;
    tick;
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    drain("t1_drain");
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    base = gq.size();
    set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
    wait_grants("t2_g0", base + 1);
    set_req(0, 1'b0, 32'h48, 32'h0, 4'h0);
    wait_grants("t2_g2", base + 3);
    chk("t2_first", 32'(gq[base]), 0);
    chk("t2_second", 32'(gq[base + 1]), 1);
    chk("t2_wrap", 32'(gq[base + 2]), 0);
    drain("t2_drain");
    set_req(0, 1'b0, 32'h1000, 32'h0, 4'h0);
    drain("t3a_drain");
    chk("t3_oob_err", 32'(last_err), 1);
    chk("t3_oob_rdata", last_rdata, 0);
    set_req(0, 1'b0, 32'h2, 32'h0, 4'h0);
    drain("t3b_drain");
    chk("t3_misaligned_err", 32'(last_err), 1);
    set_req(0, 1'b0, 32'hFFC, 32'h0, 4'h0);
    drain("t3c_drain");
    chk("t3_top_err", 32'(last_err), 0);
    chk("t3_top_rdata", last_rdata, init_word(1023));
    set_req(0, 1'b1, 32'h20, 32'h12345678, 4'b0011);
    drain("t4a_drain");
    chk("t4_write_rdata", last_rdata, 0);
    set_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
    drain("t4b_drain");
    w = init_word(8);
    chk("t4_read_merge", last_rdata, {w[31:16], 16'h5678});
    base = gq.size();
    set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
    wait_grants("t5_busy", base + 1);
    set_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
    set_req(2, 1'b0, 32'h48, 32'h0, 4'h0);
    rst_i = 1'b1;
    #1;
    chk("t5_async_ready", 32'(req_ready_o), 0);
    chk("t5_async_rsp", 32'(rsp_valid_o), 0);
    chk("t5_async_mem_en", 32'(mem_en_o), 0);
    chk("t5_async_addr", mem_addr_o, 0);
    tick;
    set_req(0, 1'b0, 32'h4C, 32'h0, 4'h0);
    rst_i = 1'b0;
    base = gq.size();
    wait_grants("t5_regrant", base + 1);
    chk("t5_req0_wins", 32'(gq[base]), 0);
    drain("t5_drain");
    set_req(2, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    drain("t6a_drain");
    chk("t6_write_rdata", last_rdata, 0);
    set_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
    drain("t6b_drain");
    chk("t6_unchanged", last_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < N; r++) if (!req_valid[r] && $urandom_range(0, 3) == 0) rand_req(r);
      tick;
    end
    drain("rand_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
